binary_to_grey_converter: RTL and testbench



---
 rtl/binary_to_grey_converter_pkg.sv | 16 +
 rtl/binary_to_grey_converter_gray_to_binary.sv | 11 +
 rtl/binary_to_grey_converter.sv | 64 ++++++
 tb/tb_binary_to_grey_converter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/binary_to_grey_converter_pkg.sv
// gray_pkg: shared Gray encode/decode helpers, computed at the maximum width.
// Callers zero-extend their operand and truncate the result, which is exact because the high zero bits drop out of both transforms.
package gray_pkg;
    localparam int GRAY_MAX_WIDTH = 32;
    typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = '0;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/binary_to_grey_converter_gray_to_binary.sv
// gray_to_binary: combinational Gray decoder (prefix XOR from the MSB).
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] binary_out
);
    assign binary_out = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(gray_in)));
endmodule

// File: rtl/binary_to_grey_converter.sv
// binary_to_grey_converter: combinational binary-to-Gray path, registered Gray output with
// valid and unit-step tracking, and a Gray-to-binary decoder for round-trip use.
module binary_to_grey_converter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] binary_in,
    output logic [WIDTH-1:0] gray_out,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic [WIDTH-1:0] gray_q,
    output logic             out_valid,
    output logic             unit_step,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] binary_out
);
    generate
        if (WIDTH < 2 || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
            $error("binary_to_grey_converter: WIDTH out of range");
        end
    endgenerate

    logic [WIDTH-1:0] w_gray;
    logic [WIDTH-1:0] w_prev_inc;
    logic [WIDTH-1:0] r_gray_q;
    logic [WIDTH-1:0] r_prev_bin;
    logic             r_out_valid;
    logic             r_unit_step;
    logic             r_have_prev;

    // Depends on binary_in alone so it works with clk/rst_n left floating.
    assign w_gray     = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(binary_in)));
    assign gray_out   = w_gray;
    assign w_prev_inc = r_prev_bin + WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray_q    <= '0;
            r_prev_bin  <= '0;
            r_out_valid <= 1'b0;
            r_unit_step <= 1'b0;
            r_have_prev <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            r_unit_step <= in_valid && r_have_prev && (binary_in == w_prev_inc);
            if (in_valid) begin
                r_gray_q    <= w_gray;
                r_prev_bin  <= binary_in;
                r_have_prev <= 1'b1;
            end
        end
    end

    assign gray_q    = r_gray_q;
    assign out_valid = r_out_valid;
    assign unit_step = r_unit_step;

    gray_to_binary #(.WIDTH(WIDTH)) u_dec (
        .gray_in   (gray_in),
        .binary_out(binary_out)
    );
endmodule

// File: tb/tb_binary_to_grey_converter.sv
// tb_binary_to_grey_converter: directed vectors for encode, round trip at 4 and 8 bits,
// registered path, unit_step, hold and asynchronous reset.
module tb_binary_to_grey_converter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] binary_in = '0;
    logic [3:0] gray_in = '0;
    logic [3:0] gray_out, gray_q, binary_out;
    logic       out_valid, unit_step;
    logic [7:0] b8_in = '0;
    logic [7:0] g8_in = '0;
    logic [7:0] g8_out, g8_q, b8_out;
    logic       v8, s8;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    binary_to_grey_converter #(.WIDTH(4)) dut (
        .binary_in(binary_in), .gray_out(gray_out), .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .gray_q(gray_q), .out_valid(out_valid),
        .unit_step(unit_step), .gray_in(gray_in), .binary_out(binary_out)
    );

    binary_to_grey_converter #(.WIDTH(8)) dut8 (
        .binary_in(b8_in), .gray_out(g8_out), .clk(clk), .rst_n(rst_n),
        .in_valid(1'b0), .gray_q(g8_q), .out_valid(v8),
        .unit_step(s8), .gray_in(g8_in), .binary_out(b8_out)
    );

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
    } enc_vec_t;

    typedef struct {
        logic       valid;
        logic [3:0] bin;
        logic [3:0] exp_q;
        logic       exp_ov;
        logic       exp_us;
    } reg_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] b);
        @(negedge clk);
        in_valid = v;
        binary_in = b;
        @(posedge clk);
        #1;
    endtask

    enc_vec_t enc[11];
    reg_vec_t seq[9];

    initial begin
        enc[0]  = '{4'd0,  4'b0000};
        enc[1]  = '{4'd1,  4'b0001};
        enc[2]  = '{4'd2,  4'b0011};
        enc[3]  = '{4'd3,  4'b0010};
        enc[4]  = '{4'd4,  4'b0110};
        enc[5]  = '{4'd5,  4'b0111};
        enc[6]  = '{4'd6,  4'b0101};
        enc[7]  = '{4'd7,  4'b0100};
        enc[8]  = '{4'd8,  4'b1100};
        enc[9]  = '{4'd9,  4'b1101};
        enc[10] = '{4'd10, 4'b1111};
        seq[0] = '{1'b1, 4'd5,  4'b0111, 1'b1, 1'b0};
        seq[1] = '{1'b1, 4'd6,  4'b0101, 1'b1, 1'b1};
        seq[2] = '{1'b1, 4'd15, 4'b1000, 1'b1, 1'b0};
        seq[3] = '{1'b1, 4'd0,  4'b0000, 1'b1, 1'b1};
        seq[4] = '{1'b1, 4'd3,  4'b0010, 1'b1, 1'b0};
        seq[5] = '{1'b1, 4'd5,  4'b0111, 1'b1, 1'b0};
        seq[6] = '{1'b0, 4'd9,  4'b0111, 1'b0, 1'b0};
        seq[7] = '{1'b1, 4'd6,  4'b0101, 1'b1, 1'b1};
        seq[8] = '{1'b1, 4'd7,  4'b0100, 1'b1, 1'b1};

        #1 rst_n = 1'b0;
        #2;
        chk("reset gray_q", 32'(gray_q), 0);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset unit_step", 32'(unit_step), 0);

        for (int i = 0; i < 11; i++) begin
            binary_in = enc[i].bin;
            #5;
            chk($sformatf("encode %0d", i), 32'(gray_out), 32'(enc[i].gray));
        end

        for (int i = 0; i < 16; i++) begin
            logic [3:0] b;
            b = 4'(i);
            gray_in = b ^ (b >> 1);
            #1;
            chk($sformatf("round4 %0d", i), 32'(binary_out), 32'(b));
        end

        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            b8_in = b;
            g8_in = b ^ (b >> 1);
            #1;
            chk($sformatf("enc8 %0d", i), 32'(g8_out), 32'(g8_in));
            chk($sformatf("round8 %0d", i), 32'(b8_out), 32'(b));
        end

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(seq[i].valid, seq[i].bin);
            chk($sformatf("seq%0d gray_q", i), 32'(gray_q), 32'(seq[i].exp_q));
            chk($sformatf("seq%0d out_valid", i), 32'(out_valid), 32'(seq[i].exp_ov));
            chk($sformatf("seq%0d unit_step", i), 32'(unit_step), 32'(seq[i].exp_us));
        end

        // asynchronous reset between clock edges while state is non-zero
        @(negedge clk);
        in_valid = 1'b1;
        binary_in = 4'd8;
        #2 rst_n = 1'b0;
        #1;
        chk("async gray_q", 32'(gray_q), 0);
        chk("async out_valid", 32'(out_valid), 0);
        chk("async unit_step", 32'(unit_step), 0);
        @(posedge clk);
        #1;
        chk("held reset gray_q", 32'(gray_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'd1);
        chk("post-reset gray_q", 32'(gray_q), 32'(4'b0001));
        chk("post-reset out_valid", 32'(out_valid), 1);
        chk("post-reset unit_step", 32'(unit_step), 0);
        step(1'b1, 4'd2);
        chk("post-reset step", 32'(unit_step), 1);
        step(1'b0, 4'd3);
        chk("idle unit_step", 32'(unit_step), 0);
        chk("idle gray_q held", 32'(gray_q), 32'(4'b0011));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
